codec_init_seq: RTL and testbench

- Upstream byte-feeder for the I2C master: walks an external command table of {register, data} pairs and presents each write to the master as byte-serial loads (DIN plus copy_enable strobes).
- Waits for each transaction to leave and return to idle before issuing the next.
- Between init runs, also accepts single host read/write requests.
- Sits between the codec configuration ROM / control logic and the I2C master on the audio shield.

---
 rtl/codec_init_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_codec_init_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_init_seq.sv
// Byte feeder for the codec's I2C master. Walks a {register, data} command
// table and also serves single host read/write requests between table runs.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for start or host_req
// FETCH        | cmd_index presented, table word not yet valid
// DECODE       | classify table word: end marker, delay or register write
// LOAD_SETUP   | i2c_din driven, copy_enable low, setup time running
// STROBE_HI    | copy_enable high
// STROBE_LO    | copy_enable low, i2c_din held
// WAIT_BUSY    | waiting for the master to leave idle
// WAIT_IDLE    | waiting for the master to return to idle
// DELAY        | delay command running
// NEXT         | advance to the next table entry or finish at the last slot
// DONE         | table run complete, done held
// ERROR        | master wait timed out, error held
module codec_init_seq #(
    parameter logic [6:0] DEV_ADDR     = 7'h18,
    parameter int         IDX_W        = 6,
    parameter int         STROBE_SETUP = 4,
    parameter int         STROBE_HIGH  = 4,
    parameter int         DELAY_UNIT   = 1024,
    parameter int         TIMEOUT      = 2000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] cmd_index,
    input  logic [15:0]      cmd_word,
    input  logic             host_req,
    input  logic             host_rw,
    input  logic [7:0]       host_reg,
    input  logic [7:0]       host_wdata,
    output logic             host_ack,
    output logic [7:0]       host_rdata,
    output logic [7:0]       i2c_din,
    output logic             i2c_copy_enable,
    input  logic [7:0]       i2c_state,
    input  logic [7:0]       i2c_dout
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_LOAD_SETUP, S_STROBE_HI, S_STROBE_LO,
        S_WAIT_BUSY, S_WAIT_IDLE, S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_t;

    localparam logic [31:0]      SETUP_LD = 32'(STROBE_SETUP - 1);
    localparam logic [31:0]      HIGH_LD  = 32'(STROBE_HIGH - 1);
    localparam logic [31:0]      TO_LD    = 32'(TIMEOUT - 1);
    localparam logic [31:0]      DU       = 32'(DELAY_UNIT);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [31:0] timer;       // shared down-counter: strobe phases, delay, timeout
    logic        host_mode;
    logic        rw_lat;
    logic [7:0]  reg_lat;
    logic [7:0]  wdata_lat;
    logic [1:0]  byte_idx;

    // Address byte first, then register, then data (writes only).
    function automatic logic [7:0] byte_sel(input logic [1:0] idx, input logic rw,
                                            input logic [7:0] r, input logic [7:0] d);
        case (idx)
            2'd0:    byte_sel = {DEV_ADDR, rw};
            2'd1:    byte_sel = r;
            default: byte_sel = d;
        endcase
    endfunction

    logic last_byte;
    assign last_byte = rw_lat ? (byte_idx == 2'd1) : (byte_idx == 2'd2);

    // Sequencer with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            timer           <= '0;
            host_mode       <= 1'b0;
            rw_lat          <= 1'b0;
            reg_lat         <= '0;
            wdata_lat       <= '0;
            byte_idx        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            cmd_index       <= '0;
            host_ack        <= 1'b0;
            host_rdata      <= '0;
            i2c_din         <= '0;
            i2c_copy_enable <= 1'b0;
        end else begin
            host_ack <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        cmd_index <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_FETCH;
                    end else if (host_req) begin
                        host_mode <= 1'b1;
                        rw_lat    <= host_rw;
                        reg_lat   <= host_reg;
                        wdata_lat <= host_wdata;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        byte_idx  <= 2'd0;
                        i2c_din   <= {DEV_ADDR, host_rw};
                        timer     <= SETUP_LD;
                        state     <= S_LOAD_SETUP;
                    end
                end
                // The table word becomes valid one cycle after cmd_index moves.
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (cmd_word == 16'hFFFF) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (cmd_word[15:8] == 8'hFE) begin
                        if (cmd_word[7:0] == 8'd0) begin
                            state <= S_NEXT;
                        end else begin
                            timer <= 32'(cmd_word[7:0]) * DU - 32'd1;
                            state <= S_DELAY;
                        end
                    end else begin
                        host_mode <= 1'b0;
                        rw_lat    <= 1'b0;
                        reg_lat   <= cmd_word[15:8];
                        wdata_lat <= cmd_word[7:0];
                        byte_idx  <= 2'd0;
                        i2c_din   <= {DEV_ADDR, 1'b0};
                        timer     <= SETUP_LD;
                        state     <= S_LOAD_SETUP;
                    end
                end
                S_LOAD_SETUP: begin
                    if (timer == 32'd0) begin
                        i2c_copy_enable <= 1'b1;
                        timer           <= HIGH_LD;
                        state           <= S_STROBE_HI;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                S_STROBE_HI: begin
                    if (timer == 32'd0) begin
                        i2c_copy_enable <= 1'b0;
                        timer           <= HIGH_LD;
                        state           <= S_STROBE_LO;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                S_STROBE_LO: begin
                    if (timer == 32'd0) begin
                        if (last_byte) begin
                            timer <= TO_LD;
                            state <= S_WAIT_BUSY;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            i2c_din  <= byte_sel(byte_idx + 2'd1, rw_lat, reg_lat, wdata_lat);
                            timer    <= SETUP_LD;
                            state    <= S_LOAD_SETUP;
                        end
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                S_WAIT_BUSY: begin
                    if (i2c_state != 8'd0) begin
                        timer <= TO_LD;
                        state <= S_WAIT_IDLE;
                    end else if (timer == 32'd0) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERROR;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (i2c_state == 8'd0) begin
                        if (host_mode) begin
                            host_ack <= 1'b1;
                            if (rw_lat) host_rdata <= i2c_dout;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else if (timer == 32'd0) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERROR;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                S_DELAY: begin
                    if (timer == 32'd0) state <= S_NEXT;
                    else                timer <= timer - 32'd1;
                end
                // Last slot ends the run instead of wrapping to index 0.
                S_NEXT: begin
                    if (cmd_index == IDX_LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        cmd_index <= cmd_index + IDX_ONE;
                        state     <= S_FETCH;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_init_seq.sv
// Bench for codec_init_seq: registered table ROM, behavioural I2C master,
// and a scoreboard of expected strobed bytes checked at every copy_enable rise.
module tb_codec_init_seq;

    localparam int TO = 300;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        busy, done, error;
    logic [5:0]  cmd_index;
    logic [15:0] cmd_word;
    logic        host_req, host_rw;
    logic [7:0]  host_reg, host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic [7:0]  i2c_din;
    logic        i2c_copy_enable;
    logic [7:0]  i2c_state;
    logic [7:0]  i2c_dout;

    codec_init_seq #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .error(error), .cmd_index(cmd_index), .cmd_word(cmd_word),
        .host_req(host_req), .host_rw(host_rw), .host_reg(host_reg),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .i2c_din(i2c_din), .i2c_copy_enable(i2c_copy_enable),
        .i2c_state(i2c_state), .i2c_dout(i2c_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Table ROM: data appears the cycle after the index changes.
    logic [15:0] rom [64];
    always @(posedge clk) cmd_word <= rom[cmd_index];

    logic [7:0] exp_q[$];
    int         b0_q[$];
    int         idle_q[$];
    bit         kick = 1'b0;
    bit         master_dead = 1'b0;
    int         strobes = 0;
    int         ack_cnt = 0;
    int         last_rise = 0;

    // Strobe monitor: timing, scoreboard and transaction framing.
    logic       prev_ce = 1'b0;
    logic [7:0] prev_din = 8'd0;
    int         high_cnt = 0, low_cnt = 0, stable_cnt = 0, nbyte = 0;
    bit         low_valid = 1'b0;
    bit         rw_cur = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_ce = 1'b0; high_cnt = 0; low_cnt = 0; stable_cnt = 0;
            nbyte = 0; low_valid = 1'b0; prev_din = i2c_din;
        end else begin
            if (host_ack) ack_cnt++;
            if (i2c_copy_enable && !prev_ce) begin
                strobes++;
                chk("setup_time", 32'(stable_cnt >= 4), 32'd1);
                if (low_valid) chk("low_time", 32'(low_cnt >= 4), 32'd1);
                chk("sb_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("strobe_byte", 32'(i2c_din), 32'(exp_q.pop_front()));
                if (nbyte == 0) begin
                    rw_cur = i2c_din[0];
                    b0_q.push_back(cyc);
                end
                nbyte++;
                if (nbyte == (rw_cur ? 2 : 3)) begin
                    nbyte = 0;
                    kick = 1'b1;
                    last_rise = cyc;
                end
                high_cnt = 1;
            end else if (i2c_copy_enable) begin
                high_cnt++;
            end
            if (!i2c_copy_enable && prev_ce) begin
                chk("high_time", 32'(high_cnt), 32'd4);
                low_cnt = 1;
                low_valid = 1'b1;
            end else if (!i2c_copy_enable) begin
                low_cnt++;
            end
            stable_cnt = (i2c_din == prev_din) ? stable_cnt + 1 : 1;
            prev_din = i2c_din;
            prev_ce  = i2c_copy_enable;
        end
    end

    // Master model: idle -> 1 -> 7 -> idle some 50 cycles after the last byte.
    initial begin
        i2c_state = 8'd0;
        forever begin
            @(negedge clk);
            if (kick) begin
                kick = 1'b0;
                if (!master_dead) begin
                    repeat (50) @(negedge clk);
                    i2c_state = 8'd1;
                    repeat (10) @(negedge clk);
                    i2c_state = 8'd7;
                    repeat (10) @(negedge clk);
                    i2c_state = 8'd0;
                    idle_q.push_back(cyc);
                end
            end
        end
    end

    task automatic rom_clear();
        for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;
    endtask

    task automatic push_write(input logic [7:0] r, input logic [7:0] d);
        exp_q.push_back(8'h30);
        exp_q.push_back(r);
        exp_q.push_back(d);
    endtask

    task automatic run_table();
        bit ok;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("run_finished", 32'(ok), 32'd1);
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (host_ack) begin ok = 1'b1; break; end
        end
        host_req = 1'b0;
        chk("host_ack_seen", 32'(ok), 32'd1);
    endtask

    int gap_a, gap_b, d, acks0, s0;
    bit ok;

    initial begin
        reset_n = 1'b0; start = 1'b0; host_req = 1'b0; host_rw = 1'b0;
        host_reg = 8'd0; host_wdata = 8'd0; i2c_dout = 8'hA5;
        rom_clear();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_index", 32'(cmd_index), 0);
        chk("rst_ack", 32'(host_ack), 0);
        chk("rst_rdata", 32'(host_rdata), 0);
        chk("rst_din", 32'(i2c_din), 0);
        chk("rst_ce", 32'(i2c_copy_enable), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic two-write table.
        rom[0] = 16'h0000; rom[1] = 16'h0101; rom[2] = 16'hFFFF;
        push_write(8'h00, 8'h00); push_write(8'h01, 8'h01);
        s0 = strobes;
        run_table();
        chk("t1_strobes", 32'(strobes - s0), 32'd6);
        chk("t1_done", 32'(done), 1);
        chk("t1_index", 32'(cmd_index), 2);
        chk("t1_drained", 32'(exp_q.size()), 0);

        // Delay of 3 units between writes, then the same with zero units.
        rom_clear();
        rom[0] = 16'h0000; rom[1] = 16'hFE03; rom[2] = 16'h0101;
        push_write(8'h00, 8'h00); push_write(8'h01, 8'h01);
        b0_q.delete(); idle_q.delete();
        run_table();
        chk("gapa_samples", 32'(b0_q.size() == 2 && idle_q.size() >= 1), 1);
        gap_a = (b0_q.size() == 2 && idle_q.size() >= 1) ? b0_q[1] - idle_q[0] : 0;
        rom[1] = 16'hFE00;
        push_write(8'h00, 8'h00); push_write(8'h01, 8'h01);
        b0_q.delete(); idle_q.delete();
        run_table();
        chk("gapb_samples", 32'(b0_q.size() == 2 && idle_q.size() >= 1), 1);
        gap_b = (b0_q.size() == 2 && idle_q.size() >= 1) ? b0_q[1] - idle_q[0] : 0;
        d = gap_a - gap_b;
        chk("delay_gap_3072", 32'(d >= 3070 && d <= 3074), 1);
        chk("zero_delay_short", 32'(gap_b > 0 && gap_b < 20), 1);
        chk("t2_drained", 32'(exp_q.size()), 0);

        // Host read.
        acks0 = ack_cnt; s0 = strobes;
        exp_q.push_back(8'h31); exp_q.push_back(8'h0B);
        @(negedge clk);
        host_rw = 1'b1; host_reg = 8'h0B; host_req = 1'b1;
        wait_ack(ok);
        repeat (5) @(negedge clk);
        chk("rd_strobes", 32'(strobes - s0), 2);
        chk("rd_ack_pulses", 32'(ack_cnt - acks0), 1);
        chk("rd_rdata", 32'(host_rdata), 32'hA5);
        chk("rd_busy", 32'(busy), 0);

        // Host write.
        acks0 = ack_cnt;
        push_write(8'h22, 8'h5A);
        @(negedge clk);
        host_rw = 1'b0; host_reg = 8'h22; host_wdata = 8'h5A; host_req = 1'b1;
        wait_ack(ok);
        repeat (5) @(negedge clk);
        chk("wr_ack_pulses", 32'(ack_cnt - acks0), 1);
        chk("wr_drained", 32'(exp_q.size()), 0);

        // Timeout: master never leaves idle.
        rom_clear();
        rom[0] = 16'h0000; rom[1] = 16'h0101;
        master_dead = 1'b1;
        push_write(8'h00, 8'h00);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (error) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("to_error", 32'(ok), 1);
        d = cyc - last_rise;
        chk("to_latency", 32'(d >= TO + 8 - 2 && d <= TO + 8 + 2), 1);
        chk("to_busy", 32'(busy), 0);
        chk("to_done", 32'(done), 0);
        master_dead = 1'b0;
        push_write(8'h00, 8'h00); push_write(8'h01, 8'h01);
        run_table();
        chk("to_rerun_error", 32'(error), 0);
        chk("to_rerun_done", 32'(done), 1);
        chk("to_rerun_index", 32'(cmd_index), 2);

        // start and host_req together: table first, host afterwards.
        acks0 = ack_cnt;
        push_write(8'h00, 8'h00); push_write(8'h01, 8'h01); push_write(8'h44, 8'h55);
        @(negedge clk);
        start = 1'b1; host_req = 1'b1; host_rw = 1'b0; host_reg = 8'h44; host_wdata = 8'h55;
        @(negedge clk) start = 1'b0;
        wait_ack(ok);
        repeat (5) @(negedge clk);
        chk("both_ack_pulses", 32'(ack_cnt - acks0), 1);
        chk("both_drained", 32'(exp_q.size()), 0);
        chk("both_index", 32'(cmd_index), 2);

        // Reset in the middle of a strobe.
        push_write(8'h00, 8'h00);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (i2c_copy_enable) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("mid_strobe_seen", 32'(ok), 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async_ce_low", 32'(i2c_copy_enable), 0);
        chk("async_busy_low", 32'(busy), 0);
        @(negedge clk);
        exp_q.delete();
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_index", 32'(cmd_index), 0);

        // Full table without end marker: last slot is a write, then done.
        for (int i = 0; i < 64; i++) rom[i] = 16'hFE00;
        rom[63] = 16'h0707;
        push_write(8'h07, 8'h07);
        s0 = strobes;
        run_table();
        chk("full_done", 32'(done), 1);
        chk("full_index", 32'(cmd_index), 63);
        chk("full_strobes", 32'(strobes - s0), 3);
        repeat (10) @(negedge clk);
        chk("full_no_wrap", 32'(cmd_index), 63);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
